// File: rtl/aes_enc_round_pipe.sv
// AES-128 encryption datapath: Nr+1 register stages, one block per cycle.
// Blocks are accepted once the round-key expander has settled; output backpressure stalls every stage.
module aes_enc_round_pipe #(
  parameter int Nk       = 4,
  parameter int Nr       = 10,
  parameter int KEY_WAIT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [(Nr+1)*128-1:0] keysIn,
  input  logic                  key_ready,
  input  logic                  in_valid,
  input  logic [127:0]          in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [127:0]          out_data,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int BW = 32 * Nk;  // round-key width; matches the 128-bit block for AES-128
  localparam int CW = $clog2(KEY_WAIT + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {WAIT_KEY, SETTLE, RUN} state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [Nr:0]     vld_r;
  logic [127:0]    data_r [0:Nr-1];
  logic [127:0]    out_data_r;
  logic [127:0]    round_s [1:Nr];
  logic            stall_n_s;
  logic            accept_s;

  // Entry for byte b sits at bit offset 8*(255-b), i.e. {~b, 3'b111} is its MSB.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    return o;
  endfunction

  assign stall_n_s = ~vld_r[Nr] | out_ready;
  assign accept_s  = in_valid & in_ready;
  assign out_valid = vld_r[Nr];
  assign out_data  = out_data_r;
  assign busy      = |vld_r;

  // State and settle-counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= WAIT_KEY;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Key gating: RUN is entered on the edge where the settle count reaches KEY_WAIT-1
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    in_ready = 1'b0;
    case (state_r)
      WAIT_KEY: begin
        cnt_s = '0;
        if (key_ready) state_s = SETTLE;
        else           state_s = WAIT_KEY;
      end
      SETTLE: begin
        cnt_s = cnt_r + CW'(1);
        if (!key_ready)                       state_s = WAIT_KEY;
        else if (cnt_s == CW'(KEY_WAIT - 1))  state_s = RUN;
        else                                  state_s = SETTLE;
      end
      RUN: begin
        in_ready = stall_n_s;
        if (!key_ready) state_s = WAIT_KEY;
        else            state_s = RUN;
      end
      default: begin
        state_s = WAIT_KEY;
        cnt_s   = '0;
      end
    endcase
  end

  // Round datapath feeding stages 1..Nr; the last round skips MixColumns
  always_comb begin
    for (int r = 1; r <= Nr; r++)
      round_s[r] = ((r < Nr) ? mix_columns(sub_shift(data_r[r-1])) : sub_shift(data_r[r-1]))
                   ^ keysIn[(Nr + 1 - r)*BW - 1 -: BW];
  end

  // Inner stage data registers; contents are qualified by vld_r so no reset is needed
  always_ff @(posedge clk) begin
    if (stall_n_s) begin
      data_r[0] <= in_data ^ keysIn[(Nr + 1)*BW - 1 -: BW];
      for (int r = 1; r < Nr; r++)
        data_r[r] <= round_s[r];
    end
  end

  // Valid chain and output stage; reset discards every in-flight block
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_r      <= '0;
      out_data_r <= 128'h0;
    end else if (stall_n_s) begin
      vld_r      <= {vld_r[Nr-1:0], accept_s};
      out_data_r <= round_s[Nr];
    end
  end

endmodule

// File: tb/tb_aes_enc_round_pipe.sv
// Scoreboard bench for aes_enc_round_pipe: FIPS-197 known answers, key gating,
// random backpressure, full-pipeline stall and mid-stream reset.
module tb_aes_enc_round_pipe;

  localparam int NR = 10;
  localparam int KW = 32;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic reset, key_ready, in_valid, in_ready, out_valid, out_ready, busy;
  logic [(NR+1)*128-1:0] keysIn;
  logic [127:0] in_data, out_data;

  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] sb [$];
  logic [7:0] sbox_tab [256];
  logic rand_ready = 1'b0;
  logic fixed_ready = 1'b1;
  logic held_v = 1'b0;
  logic [127:0] held_d = 128'h0;

  aes_enc_round_pipe #(.Nk(4), .Nr(NR), .KEY_WAIT(KW)) dut (
    .clk(clk), .reset(reset), .keysIn(keysIn), .key_ready(key_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse and affine map, independent of any table
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [(NR+1)*128-1:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [(NR+1)*128-1:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[(NR+1)*128 - 1 - 32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [(NR+1)*128-1:0] ks);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] ct;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ ks[(NR+1)*128 - 1 - 8*(4*c + r) -: 8];
    for (int rnd = 1; rnd <= NR; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_tab[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < NR) begin
          s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
          s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ ks[(NR+1)*128 - 1 - 128*rnd - 8*(4*c + r) -: 8];
      end
    end
    ct = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ct[127 - 8*(4*c + r) -: 8] = s[r][c];
    return ct;
  endfunction

  task automatic send(input logic [127:0] pt, input logic [127:0] exp);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = pt;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(exp);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: block %h never accepted", pt);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || busy) && i < 1000) begin
      @(posedge clk);
      #1;
      i++;
    end
    n_chk++;
    if (sb.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL drain: %0d blocks outstanding, busy=%b", sb.size(), busy);
    end
  endtask

  // key_ready rises just after an edge; in_ready must appear after exactly KW more edges
  task automatic key_gate();
    key_ready = 1'b1;
    for (int k = 1; k <= KW; k++) begin
      @(posedge clk);
      #1;
      check_bit("key_gate_in_ready", in_ready, k == KW);
      check_bit("key_gate_busy", busy, 1'b0);
    end
  endtask

  // Output backpressure driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : fixed_ready;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks held data stays stable
  initial begin
    forever begin
      @(negedge clk);
      if (reset && out_valid) begin
        if (held_v) check("hold_stable", out_data, held_d);
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got %h, expected no output", out_data);
          end else begin
            check("out_data", out_data, sb.pop_front());
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_d = out_data;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_sbox();
    reset = 1'b0;
    key_ready = 1'b0;
    in_valid = 1'b1;
    in_data = C1_PT;
    keysIn = expand(C1_KEY);
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_in_ready", in_ready, 1'b0);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check("reset_out_data", out_data, 128'h0);
    reset = 1'b1;

    // No key yet: in_valid is held high but nothing may enter
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_bit("no_key_in_ready", in_ready, 1'b0);
    end
    key_gate();

    // FIPS-197 C.1 with cycle-exact latency
    @(negedge clk);
    check_bit("c1_accept_ready", in_ready, 1'b1);
    sb.push_back(C1_CT);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_bit("c1_latency", out_valid, 1'b0);
    for (int i = 1; i <= NR; i++) begin
      @(posedge clk);
      #1;
      check_bit("c1_latency", out_valid, i == NR);
    end
    drain();

    // FIPS-197 Appendix B
    keysIn = expand(B_KEY);
    send(B_PT, B_CT);
    drain();

    // 20 back-to-back blocks under random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(128'(i), model_enc(128'(i), keysIn));
    drain();
    rand_ready = 1'b0;
    fixed_ready = 1'b1;

    // Fill all 11 stages, stall for 50 cycles, then release
    fixed_ready = 1'b0;
    @(posedge clk);
    #2;
    for (int i = 0; i < NR + 1; i++)
      send({8'ha5, 112'h0, 8'(i)}, model_enc({8'ha5, 112'h0, 8'(i)}, keysIn));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_bit("stall_busy", busy, 1'b1);
      check_bit("stall_out_valid", out_valid, 1'b1);
      check_bit("stall_in_ready", in_ready, 1'b0);
    end
    fixed_ready = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < NR + 1; i++) begin
      @(negedge clk);
      check_bit("release_out_valid", out_valid, 1'b1);
      check_bit("release_busy", busy, 1'b1);
    end
    @(negedge clk);
    check_bit("release_busy_fall", busy, 1'b0);
    check_bit("release_out_valid_fall", out_valid, 1'b0);
    drain();

    // Reset with five blocks in flight
    for (int i = 0; i < 5; i++) send(128'(i + 100), model_enc(128'(i + 100), keysIn));
    reset = 1'b0;
    key_ready = 1'b0;
    @(posedge clk);
    #1;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_data", out_data, 128'h0);
    sb.delete();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_bit("midrst_wait_in_ready", in_ready, 1'b0);
      check_bit("midrst_wait_out_valid", out_valid, 1'b0);
    end
    key_gate();
    send(B_PT, B_CT);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_enc_round_pipe.md
Name: aes_enc_round_pipe

Overview:
- Fully pipelined AES-128 encryption datapath, directly downstream of the round-key expansion stage.
- Consumes the flat round-key bus `keysIn` and the `key_ready` flag produced by the expander.
- Accepts one 128-bit plaintext block per cycle under a valid/ready handshake and emits ciphertext 11 cycles later.
- Supports backpressure through a global pipeline stall.

Parameters:
- Nk, 4, key length in 32-bit words (only 4 supported).
- Nr, 10, number of rounds; the pipeline has Nr+1 register stages.
- KEY_WAIT, 32, cycles to wait after `key_ready` rises before any block is accepted; covers delivery of the remaining round keys.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- keysIn  in  (Nr+1)*128  round keys; key k occupies bits [((Nr+1-k)*128)-1 -: 128], so key 0 is in the MSBs.
- key_ready  in  1  from key expansion; high once early keys are committed, stays high until reset.
- in_valid  in  1  plaintext valid.
- in_data  in  128  plaintext, byte 0 = bits [127:120], column-major state.
- in_ready  out  1  block can accept `in_data` this cycle.
- out_valid  out  1  ciphertext valid.
- out_data  out  128  ciphertext, same byte order as `in_data`.
- out_ready  in  1  consumer accepts `out_data`.
- busy  out  1  any pipeline stage holds a valid block.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to WAIT_KEY; settle counter cleared.
  - All stage valid bits cleared.
  - Outputs: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0.
  - Stage data registers need not be cleared.
- FSM:
  - WAIT_KEY: `in_ready`=0. When `key_ready`=1, go to SETTLE with counter=0.
  - SETTLE: counter increments each cycle. When counter==KEY_WAIT-1, go to RUN. If `key_ready` drops, return to WAIT_KEY.
  - RUN: `in_ready` = stall_n. If `key_ready` drops, go to WAIT_KEY; blocks already in flight still drain.
- Stall:
  - stall_n = ~out_valid | out_ready.
  - When stall_n=0, every stage register and valid bit holds.
  - `in_ready` is combinational from FSM state and stall_n; it never depends on `in_valid`.
- Accept: a block is accepted when `in_valid` & `in_ready` at a clk edge.
- Stage 0: registers in_data ^ key0.
- Stages r=1..Nr-1: SubBytes (SubTable S-box per byte), ShiftRows, MixColumns over GF(2^8) with poly 0x11B, then XOR key r.
- Stage Nr: SubBytes, ShiftRows, XOR key Nr; no MixColumns.
- Valid bits shift alongside data when stall_n=1. Stage 0's valid loads accept.
- out_valid/out_data are the stage-Nr valid/data registers.
- Latency: accept at edge t gives out_valid=1 after edge t+Nr (11 clk edges including the accept edge) with zero stall.
- Throughput is one block per cycle. Stall cycles add 1:1 latency.
- Ordering: strictly in order; no block is dropped or duplicated under any `out_ready` pattern.
- A held `out_data` stays stable while out_valid & ~out_ready.
- `busy` = OR of all stage valid bits.
- Round keys are sampled combinationally at each stage every cycle; `keysIn` must be static during RUN.
- Reset mid-operation discards all in-flight blocks; no out_valid pulse follows the reset edge.
- Simultaneous accept with output stall is impossible, since `in_ready`=0 when stalled.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, 11 cycles after accept.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Key gating with the expander connected:
  - `in_ready` is 0 until exactly KEY_WAIT cycles after `key_ready` rises.
  - `in_valid` held high earlier is not accepted.
  - The first output matches the C.1 value.
- Back-to-back with backpressure:
  - Stimulus: 20 consecutive blocks (counter pattern 0..19 in the low byte), with `out_ready` toggled by a pseudo-random 50% pattern.
  - Required: 20 outputs, in order, each matching a software model; `out_data` stable during stall cycles.
- Reset mid-stream: assert reset with 5 blocks in flight -> out_valid=0, busy=0 and `in_ready`=0 on the next cycle; FSM re-waits for `key_ready`.
- Full pipeline stall:
  - Stimulus: fill all 11 stages, hold `out_ready`=0 for 50 cycles, then release.
  - Required: 11 correct outputs on consecutive cycles; busy=1 throughout, falling after the last output.
